mux_tdm_nch: RTL and testbench
==============================

Name: mux_tdm_nch

Overview:
- Parametrised W-bit, NCH-channel multiplexer with a registered output stage and valid/ready output handshake.
- Two modes:
  - direct: select-driven, 1-cycle latency.
  - scan: time-division round-robin over the channels enabled in en_mask, holding each channel for a programmable number of samples.
- Successor to the team's fixed 8:1 single-bit combinational muxes.
- Sits between parallel channel sources and a single serial consumer, e.g. a sampler, UART TX or debug bus.

Parameters:
- NCH, 8, number of input channels (>=2).
- W, 1, data width per channel.
- SELW, $clog2(NCH), select/channel-index width (derived, not overridden).
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- x_in  input  NCH*W  packed channel data; channel i = x_in[i*W +: W].
- sel  input  SELW  channel select, direct mode only.
- mode  input  1  0 = direct, 1 = scan.
- en_mask  input  NCH  channel enables, scan mode only.
- dwell  input  DWELL_W  samples per channel minus 1, scan mode only.
- out_ready  input  1  consumer ready.
- y  output  W  registered selected data.
- y_valid  output  1  y holds a sample.
- y_ch  output  SELW  channel index of the sample in y.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: y=0, y_valid=0, y_ch=0, scan pointer cur=0, dwell counter cnt=0. Reset mid-stream discards any held sample; no partial state survives.
- load = !y_valid || out_ready. Output registers update only when load=1.
- Transfer = y_valid && out_ready.
- When y_valid=1 and out_ready=0: y, y_ch and y_valid stay frozen. Input changes have no effect.
- Latency: a sample captured on edge k appears on y at edge k, i.e. 1 cycle from input to y. No combinational path from x_in to y.
- Direct mode (mode=0), on load:
  - sel < NCH: y<=x_in[sel], y_ch<=sel, y_valid<=1.
  - sel >= NCH (only possible when NCH is not a power of 2): y<=0, y_valid<=0, y_ch unchanged.
  - cur and cnt held at 0 while in direct mode.
- Scan mode (mode=1), on load:
  - en_mask==0: y_valid<=0, cur and cnt hold.
  - Otherwise, ch_eff = first enabled channel at or after cur, searching circularly (cur, cur+1, ..., NCH-1, 0, ...).
  - y<=x_in[ch_eff], y_ch<=ch_eff, y_valid<=1.
  - If cnt==dwell: cnt<=0, cur<=(ch_eff+1) mod NCH.
  - Else: cnt<=cnt+1, cur<=ch_eff.
  - Net effect: each enabled channel emits dwell+1 consecutive samples, then the next enabled channel takes over.
  - Disabled channels are skipped with no idle cycle.
  - Wrap from NCH-1 to 0 is seamless.
- en_mask may change at any time. It takes effect at the next load. If cur has been disabled, the search moves forward. cnt is not cleared by a mask change.
- dwell may change at any time. It is compared live, so if cnt > new dwell, the channel runs until cnt wraps through the DWELL_W range. Software changes dwell only when en_mask==0 or in direct mode.
- Mode transitions (mode differs from its registered previous value):
  - Into scan: cur<=0, cnt<=0 on that cycle before the search, so the first scan sample comes from the lowest enabled channel.
  - Into direct: cur and cnt cleared.
  - A held (unaccepted) sample is never altered by a mode change.
- Stalls never advance cur or cnt. Every advance is tied to a load.

Test Plan:
1. Reset/direct:
   - Stimulus: NCH=8, W=4, x_in channel i = i+3, rst 2 cycles, then mode=0, out_ready=1, sel=5.
   - Response: during reset y=0, y_valid=0. One cycle after rst low: y=8, y_ch=5, y_valid=1. sel=2 gives y=5 on the next cycle.
2. Backpressure:
   - Stimulus: direct, sel=1, out_ready=0 for 4 cycles while sel changes to 6 and x_in changes.
   - Response: y, y_ch=1 and y_valid=1 held all 4 cycles. Raising out_ready gives ch 6 data on the next cycle.
3. Scan with dwell and skip:
   - Stimulus: mode=1, en_mask=8'b1010_0101, dwell=1, out_ready=1.
   - Response: y_ch sequence 0,0,2,2,5,5,7,7,0,0..., with no gaps in y_valid.
4. Scan stall:
   - Stimulus: same as scenario 3, out_ready=0 for 3 cycles mid-pair on ch 2.
   - Response: ch 2 sample held. After release, exactly one more ch 2 sample follows, then ch 5.
5. Mask edge cases:
   - Stimulus: en_mask=0 in scan.
   - Response: y_valid drops to 0 once the held sample is accepted. en_mask=8'h80 then yields y_ch=7 continuously.
   - Stimulus: disable the current channel mid-dwell.
   - Response: the next sample comes from the next enabled channel.
6. Mode switch and reset mid-scan:
   - Stimulus: scan running at ch 5, switch to direct with sel=3, then back to scan.
   - Response: y_ch=3, then the scan restarts at the lowest enabled channel.
   - Stimulus: assert rst mid-scan.
   - Response: all outputs 0 on the next edge, and scanning resumes from ch 0 afterwards.

Source files
------------

// File: rtl/mux_tdm_nch_if.sv
// Channel-mux bus: parallel channel data and control in, registered sample plus
// valid/ready handshake out.
//   slave  : the mux side (consumes x_in/sel/mode/en_mask/dwell/out_ready,
//            drives y/y_valid/y_ch)
//   master : the environment side (sources and consumer)
interface mux_tdm_nch_if #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned W       = 1,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [NCH*W-1:0]   x_in;      // channel i = x_in[i*W +: W]
  logic [SELW-1:0]    sel;       // direct-mode select
  logic               mode;      // 0 = direct, 1 = scan
  logic [NCH-1:0]     en_mask;   // scan-mode channel enables
  logic [DWELL_W-1:0] dwell;     // samples per channel minus 1
  logic               out_ready; // consumer ready
  logic [W-1:0]       y;         // registered sample
  logic               y_valid;   // y holds a sample
  logic [SELW-1:0]    y_ch;      // channel index of y

  modport slave (
    input  x_in, sel, mode, en_mask, dwell, out_ready,
    output y, y_valid, y_ch
  );

  modport master (
    output x_in, sel, mode, en_mask, dwell, out_ready,
    input  y, y_valid, y_ch
  );
endinterface

// File: rtl/mux_tdm_nch.sv
// NCH-channel, W-bit multiplexer with a registered output stage and a
// valid/ready output handshake.
//   direct mode : y follows x_in[sel] with one cycle of latency.
//   scan mode   : round-robin over the channels enabled in en_mask, each enabled
//                 channel emitting dwell+1 consecutive samples.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : mux_tdm_nch_if.slave (x_in, sel, mode, en_mask, dwell, out_ready in;
//          y, y_valid, y_ch out)
module mux_tdm_nch #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned W       = 1,
  parameter int unsigned DWELL_W = 8
) (
  input logic           clk,
  input logic           rst,
  mux_tdm_nch_if.slave  bus
);
  localparam int unsigned SELW = $clog2(NCH);

  // Output and scan state
  logic [W-1:0]       y_q,       y_d;
  logic               y_valid_q, y_valid_d;
  logic [SELW-1:0]    y_ch_q,    y_ch_d;
  logic [SELW-1:0]    cur_q,     cur_d;
  logic [DWELL_W-1:0] cnt_q,     cnt_d;
  logic               mode_q,    mode_d;

  logic               load;
  logic               mode_change;
  logic [SELW-1:0]    cur_base;
  logic [DWELL_W-1:0] cnt_base;
  logic               found;
  logic [SELW-1:0]    ch_eff;
  logic [SELW-1:0]    ch_next;
  logic               sel_ok;

  // Index-safe channel extraction; an out-of-range index yields zero.
  function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] x,
                                        input logic [SELW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(idx) == i) r = x[i*W +: W];
    end
    return r;
  endfunction

  assign load        = !y_valid_q || bus.out_ready;
  assign mode_change = bus.mode != mode_q;
  assign sel_ok      = 32'(bus.sel) < NCH;

  // Entering scan restarts the search at channel 0 on the same cycle, so the
  // pointer and dwell count seen by the search are pre-cleared here.
  assign cur_base = mode_change ? '0 : cur_q;
  assign cnt_base = mode_change ? '0 : cnt_q;

  // Circular priority search: first enabled channel at or after cur_base.
  always_comb begin
    int unsigned j;
    found  = 1'b0;
    ch_eff = '0;
    j      = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = 32'(cur_base) + i;
      if (j >= NCH) j = j - NCH;
      if (!found && bus.en_mask[j]) begin
        found  = 1'b1;
        ch_eff = SELW'(j);
      end
    end
  end

  // Successor of ch_eff modulo NCH (NCH need not be a power of two).
  always_comb begin
    int unsigned n;
    n = 32'(ch_eff) + 1;
    if (n >= NCH) n = 0;
    ch_next = SELW'(n);
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_ch_d    = y_ch_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    mode_d    = bus.mode;

    if (!bus.mode) begin
      // Scan state is parked at zero while in direct mode.
      cur_d = '0;
      cnt_d = '0;
      if (load) begin
        if (sel_ok) begin
          y_d       = pick(bus.x_in, bus.sel);
          y_ch_d    = bus.sel;
          y_valid_d = 1'b1;
        end else begin
          y_d       = '0;
          y_valid_d = 1'b0;
        end
      end
    end else begin
      if (mode_change) begin
        cur_d = '0;
        cnt_d = '0;
      end
      if (load) begin
        if (!found) begin
          // Nothing enabled: go idle, keep scan position.
          y_valid_d = 1'b0;
        end else begin
          y_d       = pick(bus.x_in, ch_eff);
          y_ch_d    = ch_eff;
          y_valid_d = 1'b1;
          // dwell is compared live; a shrink below cnt runs until cnt wraps.
          if (cnt_base == bus.dwell) begin
            cnt_d = '0;
            cur_d = ch_next;
          end else begin
            cnt_d = cnt_base + 1'b1;
            cur_d = ch_eff;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_ch_q    <= y_ch_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_ch    = y_ch_q;
endmodule

// File: tb/tb_mux_tdm_nch.sv
module tb_mux_tdm_nch;
  localparam int unsigned NCH = 8;
  localparam int unsigned W   = 4;
  localparam int unsigned DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_tdm_nch_if #(.NCH(NCH), .W(W), .DWELL_W(DW)) bus ();

  mux_tdm_nch #(.NCH(NCH), .W(W), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Packed {y_valid, y_ch, y}
  logic [7:0] got;
  logic [7:0] exp;

  function automatic logic [NCH*W-1:0] xin_offset(input int unsigned off);
    logic [NCH*W-1:0] v;
    for (int unsigned i = 0; i < NCH; i++) v[i*W +: W] = W'(i + off);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.x_in      = xin_offset(3);
    bus.sel       = '0;
    bus.mode      = 1'b0;
    bus.en_mask   = '0;
    bus.dwell     = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = 8'h00;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d] got %h want %h", k, got, exp);
      end
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.sel = 3'd5;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = {1'b1, 3'd5, 4'd8};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL direct_sel5 got %h want %h", got, exp);
    end
    bus.sel = 3'd2;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = {1'b1, 3'd2, 4'd5};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL direct_sel2 got %h want %h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    bus.sel = 3'd1;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = {1'b1, 3'd1, 4'd4};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_first got %h want %h", got, exp);
    end
    bus.out_ready = 1'b0;
    bus.sel       = 3'd6;
    bus.x_in      = xin_offset(4);
    for (int k = 0; k < 4; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, 3'd1, 4'd4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h want %h", k, got, exp);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = {1'b1, 3'd6, 4'd10};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_release got %h want %h", got, exp);
    end
    bus.x_in = xin_offset(3);
  endtask

  task automatic test_scan_dwell();
    logic [2:0] seq [10] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0, 3'd0};
    bus.mode    = 1'b1;
    bus.en_mask = 8'b1010_0101;
    bus.dwell   = 8'd1;
    for (int k = 0; k < 10; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, seq[k], 4'(seq[k] + 3'd0) + 4'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan_seq[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_scan_stall();
    logic [2:0] seq [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd5};
    logic       rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      bus.out_ready = rdy[k];
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, seq[k], 4'(seq[k]) + 4'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan_stall[%0d] got %h want %h", k, got, exp);
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_mask_edges();
    // All disabled: valid drops, y/y_ch keep last sample.
    bus.en_mask = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b0, 3'd5, 4'd8};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mask_zero[%0d] got %h want %h", k, got, exp);
      end
    end
    bus.en_mask = 8'h80;
    for (int k = 0; k < 4; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, 3'd7, 4'd10};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mask_only7[%0d] got %h want %h", k, got, exp);
      end
    end
    // Back to A5 (finish ch7 pair, start ch0), then drop ch0 mid-dwell.
    begin
      logic [2:0] seq [4] = '{3'd7, 3'd0, 3'd2, 3'd5};
      logic [7:0] msk [4] = '{8'hA5, 8'hA5, 8'hA4, 8'hA4};
      for (int k = 0; k < 4; k++) begin
        bus.en_mask = msk[k];
        tick();
        got = {bus.y_valid, bus.y_ch, bus.y};
        exp = {1'b1, seq[k], 4'(seq[k]) + 4'd3};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL mask_disable_cur[%0d] got %h want %h", k, got, exp);
        end
      end
    end
    bus.en_mask = 8'hA5;
  endtask

  task automatic test_mode_switch();
    logic [2:0] seq [3] = '{3'd0, 3'd0, 3'd2};
    bus.mode = 1'b0;
    bus.sel  = 3'd3;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = {1'b1, 3'd3, 4'd6};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mode_to_direct got %h want %h", got, exp);
    end
    bus.mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, seq[k], 4'(seq[k]) + 4'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mode_to_scan[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [2:0] seq [3] = '{3'd0, 3'd0, 3'd2};
    rst = 1'b1;
    tick();
    got = {bus.y_valid, bus.y_ch, bus.y};
    exp = 8'h00;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_scan got %h want %h", got, exp);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, seq[k], 4'(seq[k]) + 4'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan_after_reset[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_dwell_zero();
    logic [2:0] seq [5] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0};
    bus.mode = 1'b0;
    bus.sel  = 3'd3;
    tick();
    bus.dwell = 8'd0;
    bus.mode  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      got = {bus.y_valid, bus.y_ch, bus.y};
      exp = {1'b1, seq[k], 4'(seq[k]) + 4'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL dwell_zero[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_scan_dwell();
    test_scan_stall();
    test_mask_edges();
    test_mode_switch();
    test_reset_mid_scan();
    test_dwell_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
